// File: rtl/apb_uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : apb_uart_fifo                                             |
// | Brief    : APB3 UART with TX/RX FIFOs, baud divisor, sticky error    |
// |            flags, internal loopback and level interrupt.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module apb_uart_fifo #(
   parameter int FIFO_DEPTH  = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 10
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [3:0]  PADDR,
   input  logic [31:0] PWDATA,
   input  logic        PWRITE,
   input  logic        PENABLE,
   input  logic        PSEL,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        tx,
   input  logic        rx,
   output logic        irq
);
   localparam int           c_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [c_AW:0] c_CNT_FULL = (c_AW+1)'(FIFO_DEPTH);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_START = 2'd1;
   localparam logic [1:0] c_ST_DATA  = 2'd2;
   localparam logic [1:0] c_ST_STOP  = 2'd3;

   // bus decode
   logic       w_access, w_wr, w_rd;
   logic [1:0] w_addr;
   logic       w_unused;
   assign w_addr   = PADDR[3:2];
   assign w_access = PSEL & PENABLE & ~PREADY;
   assign w_wr     = w_access & PWRITE;
   assign w_rd     = w_access & ~PWRITE;
   assign w_unused = &{1'b0, PADDR[1:0], PWDATA};

   // control and status registers
   logic [DIV_WIDTH-1:0] r_div, r_tick_cnt, w_div_eff;
   logic r_tx_en, r_rx_en, r_loop, r_ie_rx, r_ie_tx, r_ovr, r_ferr;
   logic w_ctrl_wr, w_stat_wr, w_tick;
   assign w_ctrl_wr = w_wr & (w_addr == 2'd3);
   assign w_stat_wr = w_wr & (w_addr == 2'd0);

   // TX FIFO
   logic [7:0]      r_txf_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_txf_wp, r_txf_rp;
   logic [c_AW:0]   r_txf_cnt;
   logic            w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
   // RX FIFO
   logic [7:0]      r_rxf_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_rxf_wp, r_rxf_rp;
   logic [c_AW:0]   r_rxf_cnt;
   logic            w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_push_req, w_ferr_set;

   // TX / RX engines
   logic [1:0] r_tx_state, r_rx_state;
   logic [3:0] r_tx_tcnt, r_rx_tcnt;
   logic [2:0] r_tx_bit, r_rx_bit;
   logic [7:0] r_tx_shift, r_rx_shift;
   logic       r_tx;
   logic [1:0] r_rx_sync;
   logic       r_rx_prev, w_rx_line, w_rx_fall;

   assign w_tx_empty = (r_txf_cnt == '0);
   assign w_tx_full  = (r_txf_cnt == c_CNT_FULL);
   assign w_rx_empty = (r_rxf_cnt == '0);
   assign w_rx_full  = (r_rxf_cnt == c_CNT_FULL);
   assign w_tx_pop   = (r_tx_state == c_ST_IDLE) & r_tx_en & ~w_tx_empty;
   assign w_tx_push  = w_wr & (w_addr == 2'd1) & (~w_tx_full | w_tx_pop);
   assign w_rx_pop   = w_rd & (w_addr == 2'd2) & ~w_rx_empty;
   assign w_rx_push  = w_rx_push_req & (~w_rx_full | w_rx_pop);

   assign w_div_eff = (r_div == '0) ? DIV_WIDTH'(1) : r_div;
   assign w_tick    = (r_tick_cnt >= w_div_eff - DIV_WIDTH'(1));

   // oversample tick counter, restarted by every CTRL write
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)                 r_tick_cnt <= '0;
      else if (w_ctrl_wr | w_tick) r_tick_cnt <= '0;
      else                        r_tick_cnt <= r_tick_cnt + DIV_WIDTH'(1);
   end

   // single-wait-state handshake and registered read data
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PREADY <= 1'b0;
         PRDATA <= '0;
      end else begin
         PREADY <= w_access;
         if (w_access) begin
            if (PWRITE)                 PRDATA <= '0;
            else if (w_addr == 2'd0)    PRDATA <= {25'b0, r_ferr, (r_tx_state != c_ST_IDLE), r_ovr,
                                                   w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
            else if (w_addr == 2'd2)    PRDATA <= w_rx_empty ? 32'h0 : {24'b0, r_rxf_mem[r_rxf_rp]};
            else if (w_addr == 2'd3)    PRDATA <= {11'b0, r_ie_tx, r_ie_rx, r_loop, r_rx_en, r_tx_en, 16'(r_div)};
            else                        PRDATA <= '0;
         end
      end
   end

   // CTRL register and sticky error flags (set wins over W1C)
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_div   <= DIV_WIDTH'(DEFAULT_DIV);
         r_tx_en <= 1'b1;
         r_rx_en <= 1'b1;
         r_loop  <= 1'b0;
         r_ie_rx <= 1'b0;
         r_ie_tx <= 1'b0;
         r_ovr   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_div   <= PWDATA[DIV_WIDTH-1:0];
            r_tx_en <= PWDATA[16];
            r_rx_en <= PWDATA[17];
            r_loop  <= PWDATA[18];
            r_ie_rx <= PWDATA[19];
            r_ie_tx <= PWDATA[20];
         end
         if (w_rx_push_req & ~w_rx_push) r_ovr <= 1'b1;
         else if (w_stat_wr & PWDATA[4])  r_ovr <= 1'b0;
         if (w_ferr_set)                  r_ferr <= 1'b1;
         else if (w_stat_wr & PWDATA[6])  r_ferr <= 1'b0;
      end
   end

   // FIFO storage; contents need no reset because pointers and counts do
   always_ff @(posedge PCLK) begin
      if (w_tx_push) r_txf_mem[r_txf_wp] <= PWDATA[7:0];
      if (w_rx_push) r_rxf_mem[r_rxf_wp] <= r_rx_shift;
   end

   // FIFO pointers and occupancy counts
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_txf_wp <= '0; r_txf_rp <= '0; r_txf_cnt <= '0;
         r_rxf_wp <= '0; r_rxf_rp <= '0; r_rxf_cnt <= '0;
      end else begin
         if (w_tx_push) r_txf_wp <= r_txf_wp + c_AW'(1);
         if (w_tx_pop)  r_txf_rp <= r_txf_rp + c_AW'(1);
         if (w_tx_push & ~w_tx_pop)      r_txf_cnt <= r_txf_cnt + (c_AW+1)'(1);
         else if (~w_tx_push & w_tx_pop) r_txf_cnt <= r_txf_cnt - (c_AW+1)'(1);
         if (w_rx_push) r_rxf_wp <= r_rxf_wp + c_AW'(1);
         if (w_rx_pop)  r_rxf_rp <= r_rxf_rp + c_AW'(1);
         if (w_rx_push & ~w_rx_pop)      r_rxf_cnt <= r_rxf_cnt + (c_AW+1)'(1);
         else if (~w_rx_push & w_rx_pop) r_rxf_cnt <= r_rxf_cnt - (c_AW+1)'(1);
      end
   end

   // transmitter: 16 ticks per bit, start, 8 data LSB first, stop
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_tx_state <= c_ST_IDLE;
         r_tx_tcnt  <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_tx <= (r_tx_state == c_ST_START) ? 1'b0 :
                 (r_tx_state == c_ST_DATA)  ? r_tx_shift[0] : 1'b1;
         case (r_tx_state)
            c_ST_IDLE: if (w_tx_pop) begin
               r_tx_state <= c_ST_START;
               r_tx_tcnt  <= '0;
               r_tx_shift <= r_txf_mem[r_txf_rp];
            end
            c_ST_START: if (w_tick) begin
               r_tx_tcnt <= r_tx_tcnt + 4'd1;
               if (r_tx_tcnt == 4'd15) begin
                  r_tx_state <= c_ST_DATA;
                  r_tx_bit   <= '0;
               end
            end
            c_ST_DATA: if (w_tick) begin
               r_tx_tcnt <= r_tx_tcnt + 4'd1;
               if (r_tx_tcnt == 4'd15) begin
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  if (r_tx_bit == 3'd7) r_tx_state <= c_ST_STOP;
                  else                  r_tx_bit   <= r_tx_bit + 3'd1;
               end
            end
            c_ST_STOP: if (w_tick) begin
               r_tx_tcnt <= r_tx_tcnt + 4'd1;
               if (r_tx_tcnt == 4'd15) r_tx_state <= c_ST_IDLE;
            end
            default: r_tx_state <= c_ST_IDLE;
         endcase
      end
   end

   assign tx = r_tx;

   // receive line synchroniser; idles high while the receiver is disabled
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_rx_sync <= 2'b11;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_sync <= r_rx_en ? {r_rx_sync[0], (r_loop ? r_tx : rx)} : 2'b11;
         r_rx_prev <= r_rx_sync[1];
      end
   end

   assign w_rx_line     = r_rx_sync[1];
   assign w_rx_fall     = r_rx_prev & ~w_rx_line;
   assign w_rx_push_req = (r_rx_state == c_ST_STOP) & w_tick & (r_rx_tcnt == 4'd15) & w_rx_line;
   assign w_ferr_set    = (r_rx_state == c_ST_STOP) & w_tick & (r_rx_tcnt == 4'd15) & ~w_rx_line;

   // receiver: mid-start check rejects glitches, then centre sampling
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_rx_state <= c_ST_IDLE;
         r_rx_tcnt  <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else if (!r_rx_en) begin
         r_rx_state <= c_ST_IDLE;
      end else begin
         case (r_rx_state)
            c_ST_IDLE: if (w_rx_fall) begin
               r_rx_state <= c_ST_START;
               r_rx_tcnt  <= '0;
            end
            c_ST_START: if (w_tick) begin
               r_rx_tcnt <= r_rx_tcnt + 4'd1;
               if (r_rx_tcnt == 4'd7) begin
                  r_rx_state <= w_rx_line ? c_ST_IDLE : c_ST_DATA;
                  r_rx_tcnt  <= '0;
                  r_rx_bit   <= '0;
               end
            end
            c_ST_DATA: if (w_tick) begin
               r_rx_tcnt <= r_rx_tcnt + 4'd1;
               if (r_rx_tcnt == 4'd15) begin
                  r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
                  if (r_rx_bit == 3'd7) r_rx_state <= c_ST_STOP;
                  else                  r_rx_bit   <= r_rx_bit + 3'd1;
               end
            end
            c_ST_STOP: if (w_tick) begin
               r_rx_tcnt <= r_rx_tcnt + 4'd1;
               if (r_rx_tcnt == 4'd15) r_rx_state <= c_ST_IDLE;
            end
            default: r_rx_state <= c_ST_IDLE;
         endcase
      end
   end

   assign irq = (r_ie_rx & ~w_rx_empty) | (r_ie_tx & w_tx_empty) | r_ovr | r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_apb_uart_fifo                                          |
// | Brief    : Scoreboard bench for apb_uart_fifo with a queue-based     |
// |            reference model and a serial TX frame decoder.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_apb_uart_fifo;
   localparam int DEPTH = 4;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic [3:0]  PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE, PENABLE, PSEL;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        tx, rx, irq;

   apb_uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16), .DEFAULT_DIV(10)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
      .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
      .PREADY(PREADY), .tx(tx), .rx(rx), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   int n_checks = 0;
   int n_pass   = 0;

   // scoreboards
   string       rd_name_q[$];
   logic [31:0] rd_exp_q[$];
   logic [7:0]  tx_exp_q[$];

   // reference model state
   logic [7:0] m_tx[$];
   logic [7:0] m_rx[$];
   bit m_ovr = 0, m_ferr = 0, m_tx_en = 1, m_loop = 0, m_ie_rx = 0, m_ie_tx = 0;
   int cur_div = 10;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s = '0;
      s[0] = (m_tx.size() == 0);
      s[1] = (m_tx.size() == DEPTH);
      s[2] = (m_rx.size() == 0);
      s[3] = (m_rx.size() == DEPTH);
      s[4] = m_ovr;
      s[6] = m_ferr;
      return s;
   endfunction

   function automatic logic m_irq();
      return (m_ie_rx && m_rx.size() != 0) || (m_ie_tx && m_tx.size() == 0) || m_ovr || m_ferr;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic apb(input bit wr, input logic [3:0] addr, input logic [31:0] wd);
      bit got;
      got = 0;
      @(posedge PCLK); #1;
      PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge PCLK);
         if (PREADY) got = 1;
      end
      if (!got) begin
         n_checks++;
         $display("FAIL apb_timeout: PREADY got 0, expected 1");
         if (!wr && rd_exp_q.size() != 0) begin
            void'(rd_exp_q.pop_back());
            void'(rd_name_q.pop_back());
         end
      end
      @(posedge PCLK); #1;
      PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   task automatic rd(input logic [3:0] addr, input logic [31:0] want, input string name);
      rd_name_q.push_back(name);
      rd_exp_q.push_back(want);
      apb(1'b0, addr, 32'h0);
   endtask

   task automatic model_rx_frame(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok)                m_ferr = 1;
      else if (m_rx.size() < DEPTH) m_rx.push_back(b);
      else                         m_ovr = 1;
   endtask

   task automatic set_ctrl(input int div, input bit txen, input bit rxen, input bit loop,
                           input bit ierx, input bit ietx);
      apb(1'b1, 4'hC, {11'b0, ietx, ierx, loop, rxen, txen, 16'(div)});
      cur_div = (div == 0) ? 1 : div;
      m_tx_en = txen; m_loop = loop; m_ie_rx = ierx; m_ie_tx = ietx;
      if (txen) while (m_tx.size() != 0) tx_exp_q.push_back(m_tx.pop_front());
   endtask

   task automatic tx_byte(input logic [7:0] b);
      apb(1'b1, 4'h4, {24'hABCDEF, b});
      if (!m_tx_en) begin
         if (m_tx.size() < DEPTH) m_tx.push_back(b);
      end else begin
         tx_exp_q.push_back(b);
         if (m_loop) model_rx_frame(b, 1'b1);
      end
   endtask

   task automatic drive_rx(input logic [7:0] b, input bit stop_ok);
      int d;
      d = cur_div;
      rx = 1'b0;                                      wait_cyc(16*d);
      for (int k = 0; k < 8; k++) begin rx = b[k];    wait_cyc(16*d); end
      rx = stop_ok;                                   wait_cyc(16*d);
      rx = 1'b1;                                      wait_cyc(16*d);
      model_rx_frame(b, stop_ok);
   endtask

   // APB read monitor: compares every completed read against the scoreboard
   initial forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PREADY && !PWRITE) begin
         if (rd_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: got 0x%08h, expected no read", PRDATA);
         end else check(rd_name_q.pop_front(), PRDATA, rd_exp_q.pop_front());
      end
   end

   // serial TX monitor: decodes frames at bit centres
   logic       mon_prev = 1'b1;
   logic [7:0] mon_b;
   logic       mon_stop;
   int         mon_d;
   initial forever begin
      @(negedge PCLK);
      if (!PRESET && mon_prev && !tx) begin
         mon_d = cur_div;
         repeat (8*mon_d) @(negedge PCLK);
         check("tx_start_bit", {31'b0, tx}, 32'h0);
         for (int k = 0; k < 8; k++) begin
            repeat (16*mon_d) @(negedge PCLK);
            mon_b[k] = tx;
         end
         repeat (16*mon_d) @(negedge PCLK);
         mon_stop = tx;
         if (tx_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected_frame: got 0x%02h, expected no frame", mon_b);
         end else check("tx_frame", {23'b0, mon_stop, mon_b}, {23'b0, 1'b1, tx_exp_q.pop_front()});
      end
      mon_prev = tx;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int d, n;
      PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; rx = 1'b1;
      PRESET = 1'b1;
      wait_cyc(3);
      PRESET = 1'b0;
      @(negedge PCLK);
      check("reset_tx", {31'b0, tx}, 32'h1);
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_pready", {31'b0, PREADY}, 32'h0);
      check("reset_prdata", PRDATA, 32'h0);
      rd(4'h0, 32'h0000_0005, "status_reset");
      rd(4'hC, 32'h0003_000A, "ctrl_reset");
      rd(4'h4, 32'h0, "txdata_reads_zero");
      rd(4'h8, 32'h0, "rxdata_empty");

      // loopback with random divisor and burst length
      for (int it = 0; it < 3; it++) begin
         d = $urandom_range(1, 3);
         n = $urandom_range(1, 3);
         set_ctrl(d, 1, 1, 1, 0, 0);
         rd(4'hC, {11'b0, 5'b00111, 16'(d)}, "ctrl_loopback");
         for (int j = 0; j < n; j++) tx_byte(8'($urandom));
         wait_cyc(n*170*cur_div + 60);
         rd(4'h0, m_status(), "status_lb_full");
         while (m_rx.size() != 0) begin
            b = m_rx.pop_front();
            rd(4'h8, {24'h0, b}, "rxdata_lb");
         end
         rd(4'h0, m_status(), "status_lb_drained");
      end

      // TX buffering with transmitter disabled, overflowing write dropped
      d = $urandom_range(1, 2);
      set_ctrl(d, 0, 1, 0, 0, 0);
      for (int j = 0; j < 5; j++) tx_byte(8'($urandom));
      rd(4'h0, m_status(), "status_tx_full");
      wait_cyc(50);
      check("tx_idle_disabled", {31'b0, tx}, 32'h1);
      set_ctrl(d, 1, 1, 0, 0, 0);
      wait_cyc(4*170*cur_div + 60);
      check("tx_frames_done", tx_exp_q.size(), 32'h0);
      rd(4'h0, m_status(), "status_tx_drained");

      // external RX overrun
      d = $urandom_range(2, 3);
      set_ctrl(d, 1, 1, 0, 0, 0);
      for (int j = 0; j < 5; j++) drive_rx(8'($urandom), 1'b1);
      rd(4'h0, m_status(), "status_rx_overrun");
      @(negedge PCLK);
      check("irq_overrun", {31'b0, irq}, {31'b0, m_irq()});
      apb(1'b1, 4'h0, 32'h10);
      m_ovr = 0;
      rd(4'h0, m_status(), "status_ovr_cleared");
      @(negedge PCLK);
      check("irq_ovr_cleared", {31'b0, irq}, {31'b0, m_irq()});
      set_ctrl(d, 1, 1, 0, 1, 0);
      @(negedge PCLK);
      check("irq_ie_rx", {31'b0, irq}, {31'b0, m_irq()});
      while (m_rx.size() != 0) begin
         b = m_rx.pop_front();
         rd(4'h8, {24'h0, b}, "rxdata_ext");
      end
      rd(4'h8, 32'h0, "rxdata_after_drain");
      @(negedge PCLK);
      check("irq_rx_drained", {31'b0, irq}, {31'b0, m_irq()});

      // framing error, then a short glitch
      set_ctrl(d, 1, 1, 0, 0, 0);
      drive_rx(8'($urandom), 1'b0);
      rd(4'h0, m_status(), "status_frame_err");
      @(negedge PCLK);
      check("irq_frame_err", {31'b0, irq}, {31'b0, m_irq()});
      apb(1'b1, 4'h0, 32'h40);
      m_ferr = 0;
      rd(4'h0, m_status(), "status_ferr_cleared");
      rx = 1'b0; wait_cyc(3*cur_div);
      rx = 1'b1; wait_cyc(40*cur_div);
      rd(4'h0, m_status(), "status_glitch");
      @(negedge PCLK);
      check("irq_glitch", {31'b0, irq}, {31'b0, m_irq()});

      // TX-empty interrupt
      d = $urandom_range(1, 3);
      set_ctrl(d, 0, 1, 0, 0, 1);
      @(negedge PCLK);
      check("irq_tx_idle", {31'b0, irq}, {31'b0, m_irq()});
      tx_byte(8'($urandom));
      @(negedge PCLK);
      check("irq_tx_pending", {31'b0, irq}, {31'b0, m_irq()});
      rd(4'h0, m_status(), "status_tx_pending");
      set_ctrl(d, 1, 1, 0, 0, 1);
      wait_cyc(5);
      @(negedge PCLK);
      check("irq_tx_popped", {31'b0, irq}, {31'b0, m_irq()});
      wait_cyc(170*cur_div + 60);
      rd(4'h0, m_status(), "status_final");

      wait_cyc(10);
      check("tx_scoreboard_empty", tx_exp_q.size(), 32'h0);
      check("rd_scoreboard_empty", rd_exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
